gen_scheduler: RTL
==================

GEN_SCHEDULER -- requirements
Module: gen_scheduler

Interface
REQ-001 Parameter: DATA_W, 8, width of dataout1/dataout2.
REQ-002 Parameter: PERIOD_W, 16, width of the period input and the interval timer.
REQ-003 Parameter: CNT_W, 8, width of burst_len and the sample counter.
REQ-004 Parameter: SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1.
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 Port: clk  input  1  rising-edge clock.
REQ-007 Port: rst  input  1  asynchronous active-high reset.
REQ-008 Port: start  input  1  begin a run; sampled only in IDLE.
REQ-009 Port: abort  input  1  terminate the run immediately.
REQ-010 Port: period  input  PERIOD_W  cycles between samples; 0 is treated as 1.
REQ-011 Port: burst_len  input  CNT_W  samples per run; 0 means continuous.
REQ-012 Port: dataout1  output  DATA_W  pseudo-random sample.
REQ-013 Port: dataout2  output  DATA_W  dataout1+1 mod 2^DATA_W.
REQ-014 Port: valid  output  1  sample pair available.
REQ-015 Port: ready  input  1  consumer accepts the sample.
REQ-016 Port: busy  output  1  high in every state except IDLE.
REQ-017 Port: done  output  1  one-cycle pulse when a run completes.
REQ-018 Port: elapsed  output  32  busy-cycle count of the current or last run.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, WAIT, EMIT and DONE.
REQ-020 IDLE with start=1: latch period (P=max(period,1)) and burst_len, load timer=P, clear sample count, clear elapsed, go to WAIT.
REQ-021 WAIT: decrement timer each cycle; on the cycle timer==1, step the LFSR, register the outputs, set valid=1 and go to EMIT; valid first rises P cycles after the start edge.
REQ-022 LFSR step: fb=l[0]^l[2]^l[3]^l[5]; l_next={fb,l[15:1]}; dataout1=l_next[DATA_W-1:0].
REQ-023 dataout2 SHALL be registered in the same cycle as dataout1 and SHALL equal dataout1+1, wrapping 8'hFF to 8'h00.
REQ-024 EMIT: while valid=1 and ready=0, dataout1, dataout2 and valid SHALL hold stable.
REQ-025 EMIT with ready=1: the transfer completes and count increments; go to DONE if burst_len!=0 and count+1==burst_len, otherwise reload timer=P and go to WAIT; valid drops the next cycle.
REQ-026 ready SHALL be ignored outside EMIT.
REQ-027 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-028 start SHALL be ignored in any state other than IDLE.
REQ-029 abort=1 in WAIT, EMIT or DONE SHALL force IDLE on the next edge: valid drops without a handshake, done is not pulsed, and dataout1/dataout2 keep their last value.
REQ-030 abort SHALL take priority over ready and over timer expiry in the same cycle; abort in IDLE SHALL have no effect.
REQ-031 elapsed SHALL increment every cycle busy=1, saturate at 32'hFFFF_FFFF, and hold its value in IDLE until the next start.
REQ-032 The LFSR SHALL NOT be reinitialised by start or abort; its sequence continues across runs.
REQ-033 With burst_len=0 the block SHALL loop WAIT/EMIT until abort; the count wraps silently.

Reset
REQ-034 rst=1 SHALL force, asynchronously: state=IDLE, valid=0, done=0, busy=0, dataout1=0, dataout2=0, elapsed=0, timer=0, count=0, LFSR=SEED.
REQ-035 Reset asserted mid-run SHALL discard the run with no done pulse; the first start after reset SHALL reproduce the sequence from SEED.

Structure
REQ-036 Shared package gen_sched_pkg SHALL hold the state enum, LFSR tap constants, DEFAULT_SEED and the default widths.
REQ-037 The LFSR SHALL be a separate sub-module gen_lfsr with inputs clk, rst, step and seed, and output value; the FSM, timer, counters and output registers stay in gen_scheduler.

Verification
REQ-038 Test 1: reset, then start with period=1, burst_len=1, ready=1 -> valid high for one cycle, 1 cycle after start; dataout1=8'h70, dataout2=8'h71; done pulses once; elapsed=3.
REQ-039 Test 2: period=4, burst_len=3, ready=1 -> valid rises at cycles 4, 9 and 14 after start; exactly one done pulse follows.
REQ-040 Test 3: ready held at 0 for 5 cycles during EMIT -> data and valid stable for all 5 cycles; one transfer completes when ready rises.
REQ-041 Test 4: abort asserted in the same cycle as valid&&ready -> next cycle shows IDLE, valid=0, no done pulse, count not advanced.
REQ-042 Test 5: period=0, burst_len=0, run for 20 samples, then abort -> samples spaced 2 cycles apart with ready=1; start during the run is ignored; elapsed holds after abort.
REQ-043 Test 6: assert rst mid-EMIT, then restart -> all outputs 0 immediately; the first sample after restart is again 8'h70.

Source files
------------

// File: rtl/gen_sched_pkg.sv
// Shared types and constants for the sample scheduler and its LFSR.
// Pure declarations; no timing or backpressure of its own.
package gen_sched_pkg;

  localparam int unsigned DEFAULT_DATA_W   = 8;
  localparam int unsigned DEFAULT_PERIOD_W = 16;
  localparam int unsigned DEFAULT_CNT_W    = 8;
  localparam int unsigned LFSR_W           = 16;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
  // Feedback taps at bits 0, 2, 3 and 5 of the current value.
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'h002D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {^(l & LFSR_TAPS), l[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/gen_lfsr.sv
// 16-bit right-shifting Fibonacci LFSR; advances one step per cycle with step high.
// Value is registered; a zero seed falls back to the default so the register never locks up.
module gen_lfsr
  import gen_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] value_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= (seed == '0) ? DEFAULT_SEED : seed;
    end else if (step) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/gen_scheduler.sv
// Periodic pseudo-random sample generator: first valid P cycles after start, then P cycles after each accept.
// Holds the sample pair stable under ready=0; abort returns to IDLE at the next edge without a done pulse.
module gen_scheduler
  import gen_sched_pkg::*;
#(
  parameter int unsigned       DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned       PERIOD_W = DEFAULT_PERIOD_W,
  parameter int unsigned       CNT_W    = DEFAULT_CNT_W,
  parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [PERIOD_W-1:0] period,
  input  logic [CNT_W-1:0]    burst_len,
  output logic [DATA_W-1:0]   dataout1,
  output logic [DATA_W-1:0]   dataout2,
  output logic                valid,
  input  logic                ready,
  output logic                busy,
  output logic                done,
  output logic [31:0]         elapsed
);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [CNT_W-1:0]    burst_q, burst_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [31:0]         elapsed_q, elapsed_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   d1_q, d1_d;
  logic [DATA_W-1:0]   d2_q, d2_d;

  logic                lfsr_step;
  logic [LFSR_W-1:0]   lfsr_val;
  logic [DATA_W-1:0]   sample;
  logic [CNT_W-1:0]    count_inc;
  logic [PERIOD_W-1:0] period_eff;

  gen_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .seed  (SEED),
    .value (lfsr_val)
  );

  // The sample is taken from the post-step value so it lands in the same edge as the step.
  assign sample     = DATA_W'(lfsr_next(lfsr_val));
  assign count_inc  = count_q + 1'b1;
  assign period_eff = (period == '0) ? PERIOD_W'(1) : period;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    period_d  = period_q;
    burst_d   = burst_q;
    count_d   = count_q;
    elapsed_d = elapsed_q;
    valid_d   = valid_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    lfsr_step = 1'b0;

    if (state_q != IDLE && elapsed_q != '1) begin
      elapsed_d = elapsed_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          period_d  = period_eff;
          burst_d   = burst_len;
          timer_d   = period_eff;
          count_d   = '0;
          elapsed_d = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q - 1'b1;
        if (timer_q <= PERIOD_W'(1)) begin
          lfsr_step = 1'b1;
          d1_d      = sample;
          d2_d      = sample + 1'b1;
          valid_d   = 1'b1;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (ready) begin
          count_d = count_inc;
          valid_d = 1'b0;
          if (burst_q != '0 && count_inc == burst_q) begin
            state_d = DONE;
          end else begin
            timer_d = period_q;
            state_d = WAIT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides whatever the state decided above, including a pending step or transfer.
    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      valid_d   = 1'b0;
      lfsr_step = 1'b0;
      d1_d      = d1_q;
      d2_d      = d2_q;
      count_d   = count_q;
      timer_d   = timer_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      period_q  <= '0;
      burst_q   <= '0;
      count_q   <= '0;
      elapsed_q <= '0;
      valid_q   <= 1'b0;
      d1_q      <= '0;
      d2_q      <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      burst_q   <= burst_d;
      count_q   <= count_d;
      elapsed_q <= elapsed_d;
      valid_q   <= valid_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
    end
  end

  assign dataout1 = d1_q;
  assign dataout2 = d2_q;
  assign valid    = valid_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign elapsed  = elapsed_q;

endmodule
